// File: rtl/io_input_port_if.sv
// Data-memory bus bundle between the core and io_input_port.
// The core drives we/address/write_data; the peripheral returns
// combinational read_data and hit.
interface io_input_port_if;
   logic        we;
   logic [31:0] address;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        hit;

   modport master (
      output we, address, write_data,
      input  read_data, hit
   );

   modport slave (
      input  we, address, write_data,
      output read_data, hit
   );
endinterface

// File: rtl/io_input_port.sv
// io_input_port: memory-mapped input peripheral.
// - Synchronises and debounces push-buttons and slide switches.
// - Records button presses in a sticky W1C EDGE register.
// - Counts button-0 presses in COUNT; any write to COUNT clears it.
// Optional build macro IO_INPUT_IRQ_EN adds the MASK register at 0xC and a
// registered irq output; without it 0xC reads 0 and no MASK flops exist.
//
// Bus semantics: there is no valid/ready handshake. hit is a pure address
// decode. read_data is combinational and side-effect free, 0 when hit=0.
// A write takes effect at the clk edge where we & hit are both 1.
// address[1:0] is ignored.
module io_input_port #(
   parameter int          N_BTN           = 4,
   parameter int          N_SW            = 8,
   parameter int          DEBOUNCE_CYCLES = 50000,
   parameter logic [31:0] BASE_ADDR       = 32'h0000_0100
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_BTN-1:0] btn_raw,
   input  logic [N_SW-1:0]  sw_raw,
   io_input_port_if.slave   bus
`ifdef IO_INPUT_IRQ_EN
   ,
   output logic             irq
`endif
);

   localparam int             N_IN     = N_BTN + N_SW;
   localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   // Buttons occupy the low bits, switches sit directly above them,
   // which is also the STATUS layout.
   logic [N_IN-1:0]  raw;
   logic [N_IN-1:0]  sync1_q;
   logic [N_IN-1:0]  sync2_q;
   logic [N_IN-1:0]  stable_q;
   logic [N_IN-1:0]  stable_d;
   logic [CW-1:0]    cnt_q [N_IN];
   logic [CW-1:0]    cnt_d [N_IN];

   logic [N_BTN-1:0] btn_prev_q;
   logic [N_BTN-1:0] press;
   logic [N_BTN-1:0] edge_q;
   logic [N_BTN-1:0] edge_d;
   logic [15:0]      count_q;
   logic [15:0]      count_d;

   logic             hit;
   logic [1:0]       offset;
   logic             wr_edge;
   logic             wr_count;
   logic [31:0]      status;
   logic [31:0]      rdata;
   logic             unused_bus;

   assign raw = {sw_raw, btn_raw};

   // Two-flop synchroniser for every raw pin.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
      end
   end

   // Debounce next state: a level is accepted only after it has differed
   // from the stable level for DEBOUNCE_CYCLES consecutive edges.
   always_comb begin
      stable_d = stable_q;
      for (int i = 0; i < N_IN; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != stable_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               stable_d[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   // Debounce state: stable levels, per-bit counters, previous button level.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stable_q   <= '0;
         btn_prev_q <= '0;
         for (int i = 0; i < N_IN; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         stable_q   <= stable_d;
         btn_prev_q <= stable_q[N_BTN-1:0];
         for (int i = 0; i < N_IN; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   // One-cycle pulse in the cycle a debounced button first reads 1.
   assign press = stable_q[N_BTN-1:0] & ~btn_prev_q;

   assign hit      = (bus.address[31:4] == BASE_ADDR[31:4]);
   assign offset   = bus.address[3:2];
   assign wr_edge  = bus.we & hit & (offset == 2'd1);
   assign wr_count = bus.we & hit & (offset == 2'd2);

   // EDGE and COUNT next state; a press in the same cycle as a clearing
   // write always survives.
   always_comb begin
      edge_d  = (edge_q & ~(wr_edge ? bus.write_data[N_BTN-1:0] : {N_BTN{1'b0}}))
                | press;
      count_d = count_q;
      if (wr_count) begin
         count_d = '0;
      end
      if (press[0]) begin
         count_d = count_d + 16'd1;
      end
   end

   // Event registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         edge_q  <= '0;
         count_q <= '0;
      end else begin
         edge_q  <= edge_d;
         count_q <= count_d;
      end
   end

`ifdef IO_INPUT_IRQ_EN
   logic             wr_mask;
   logic [N_BTN-1:0] mask_q;
   logic             irq_q;

   assign wr_mask = bus.we & hit & (offset == 2'd3);

   // Interrupt mask register and registered interrupt request.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mask_q <= '0;
         irq_q  <= 1'b0;
      end else begin
         if (wr_mask) begin
            mask_q <= bus.write_data[N_BTN-1:0];
         end
         irq_q <= |(edge_q & mask_q);
      end
   end

   assign irq = irq_q;
`endif

   // Read data mux; unused bits and misses read as 0.
   always_comb begin
      status           = '0;
      status[N_IN-1:0] = stable_q;
      rdata            = '0;
      if (hit) begin
         case (offset)
            2'd0:    rdata = status;
            2'd1:    rdata[N_BTN-1:0] = edge_q;
            2'd2:    rdata[15:0] = count_q;
`ifdef IO_INPUT_IRQ_EN
            2'd3:    rdata[N_BTN-1:0] = mask_q;
`endif
            default: rdata = '0;
         endcase
      end
   end

   assign bus.read_data = rdata;
   assign bus.hit       = hit;

   // Byte-lane bits and upper write-data bits carry no meaning here.
   assign unused_bus = &{1'b0, bus.address[1:0], bus.write_data[31:N_BTN]};

endmodule

// File: tb/tb_io_input_port.sv
// Directed testbench for io_input_port (DEBOUNCE_CYCLES=4, BASE_ADDR=0x100).
module tb_io_input_port;

   localparam int          N_BTN = 4;
   localparam int          N_SW  = 8;
   localparam int          DC    = 4;
   localparam logic [31:0] BASE  = 32'h0000_0100;

   logic             clk = 1'b0;
   logic             reset;
   logic [N_BTN-1:0] btn_raw;
   logic [N_SW-1:0]  sw_raw;
`ifdef IO_INPUT_IRQ_EN
   logic             irq;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   io_input_port_if bus ();

   io_input_port #(
      .N_BTN           (N_BTN),
      .N_SW            (N_SW),
      .DEBOUNCE_CYCLES (DC),
      .BASE_ADDR       (BASE)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .btn_raw (btn_raw),
      .sw_raw  (sw_raw),
      .bus     (bus)
`ifdef IO_INPUT_IRQ_EN
      ,
      .irq     (irq)
`endif
   );

   // clock
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Advance n rising edges, then settle 1 time unit past the edge.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
      bus.address = a;
      bus.we      = 1'b0;
      #1;
      check(tag, bus.read_data, exp);
   endtask

   // Write occupies exactly one rising edge.
   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      bus.address    = a;
      bus.write_data = d;
      bus.we         = 1'b1;
      @(posedge clk);
      #1;
      bus.we         = 1'b0;
      bus.write_data = '0;
   endtask

   initial begin
      reset          = 1'b0;
      btn_raw        = '0;
      sw_raw         = '0;
      bus.we         = 1'b0;
      bus.address    = '0;
      bus.write_data = '0;
      tick(3);
      reset = 1'b1;
      tick(2);

      // 1. reset state and address decode
      rd(32'h100, 32'h0, "rst_status");
      rd(32'h104, 32'h0, "rst_edge");
      rd(32'h108, 32'h0, "rst_count");
      tick(1);
      rd(32'h10C, 32'h0, "rst_mask");
      rd(32'h200, 32'h0, "miss_rdata");
      check("miss_hit", {31'b0, bus.hit}, 32'h0);
      tick(1);
      bus.address = 32'h10B;
      #1;
      check("hit_base", {31'b0, bus.hit}, 32'h1);

      // 2. btn1 press: STATUS after 2+DC edges, EDGE one edge later
      tick(1);
      btn_raw = 4'b0010;
      for (int k = 1; k <= 5; k++) begin
         tick(1);
         rd(32'h100, 32'h0, "btn1_early");
      end
      tick(1);
      rd(32'h100, 32'h2, "btn1_status");
      tick(1);
      rd(32'h104, 32'h2, "btn1_edge");
      tick(10);
      rd(32'h104, 32'h2, "btn1_edge_hold");
      rd(32'h107, 32'h2, "addr_low_ignored");

      // asynchronous reset while state is live
      tick(1);
      reset = 1'b0;
      #1;
      rd(32'h100, 32'h0, "arst_status");
      rd(32'h104, 32'h0, "arst_edge");
      tick(1);
      reset = 1'b1;
      // reset again mid-count: the count must restart from zero
      tick(4);
      reset = 1'b0;
      #1;
      rd(32'h100, 32'h0, "arst_midcount");
      tick(1);
      reset = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         tick(1);
         rd(32'h100, 32'h0, "post_rst_early");
      end
      tick(1);
      rd(32'h100, 32'h2, "post_rst_status");
      tick(1);
      rd(32'h104, 32'h2, "post_rst_edge");
      btn_raw = 4'b0000;
      tick(10);
      rd(32'h100, 32'h0, "btn1_released");
      rd(32'h104, 32'h2, "release_no_edge");

      // 3. glitch shorter than the debounce window, then a bounce
      tick(1);
      btn_raw[0] = 1'b1;
      tick(3);
      btn_raw[0] = 1'b0;
      tick(10);
      rd(32'h100, 32'h0, "glitch_status");
      rd(32'h104, 32'h2, "glitch_edge");
      rd(32'h108, 32'h0, "glitch_count");
      tick(1);
      btn_raw[0] = 1'b1;
      tick(1);
      btn_raw[0] = 1'b0;
      tick(1);
      btn_raw[0] = 1'b1;
      tick(12);
      rd(32'h108, 32'h1, "bounce_count");
      rd(32'h104, 32'h3, "bounce_edge");
      rd(32'h100, 32'h1, "bounce_status");
      tick(1);
      wr(32'h104, 32'h1);
      rd(32'h104, 32'h2, "w1c_bit0");
      btn_raw[0] = 1'b0;
      tick(10);
      rd(32'h108, 32'h1, "release_no_count");

      // 4. switches and read-only STATUS
      tick(1);
      sw_raw = 8'hA5;
      tick(5);
      rd(32'h100, 32'h0, "sw_early");
      tick(1);
      rd(32'h100, 32'h0000_0A50, "sw_status");
      wr(32'h100, 32'hFFFF_FFFF);
      rd(32'h100, 32'h0000_0A50, "status_ro");
      wr(32'h204, 32'hF);
      rd(32'h104, 32'h2, "miss_write_ignored");

      // 5. set wins over W1C in the same cycle
      tick(1);
      btn_raw[1] = 1'b1;
      tick(6);
      wr(32'h104, 32'h2);
      rd(32'h104, 32'h2, "edge_set_wins");
      wr(32'h104, 32'h2);
      rd(32'h104, 32'h0, "w1c_bit1");
      btn_raw[1] = 1'b0;
      tick(10);

      // COUNT: write clear, wrap, write coinciding with press
      wr(32'h108, 32'h1234);
      rd(32'h108, 32'h0, "count_write_clear");
      force dut.count_q = 16'hFFFF;
      #1;
      release dut.count_q;
      rd(32'h108, 32'h0000_FFFF, "count_forced");
      tick(1);
      btn_raw[0] = 1'b1;
      tick(6);
      rd(32'h108, 32'h0000_FFFF, "count_pre_wrap");
      tick(1);
      rd(32'h108, 32'h0, "count_wrap");
      btn_raw[0] = 1'b0;
      tick(10);
      btn_raw[0] = 1'b1;
      tick(7);
      rd(32'h108, 32'h1, "count_one");
      btn_raw[0] = 1'b0;
      tick(10);
      btn_raw[0] = 1'b1;
      tick(6);
      wr(32'h108, 32'h0);
      rd(32'h108, 32'h1, "count_write_and_press");
      btn_raw[0] = 1'b0;
      tick(10);

      // 6. MASK / irq
`ifdef IO_INPUT_IRQ_EN
      wr(32'h104, 32'hF);
      wr(32'h10C, 32'h4);
      rd(32'h10C, 32'h4, "mask_rd");
      btn_raw[2] = 1'b1;
      tick(6);
      check("irq_before_press", {31'b0, irq}, 32'h0);
      tick(1);
      rd(32'h104, 32'h4, "edge_bit2");
      check("irq_lag", {31'b0, irq}, 32'h0);
      tick(1);
      check("irq_set", {31'b0, irq}, 32'h1);
      wr(32'h104, 32'h4);
      tick(1);
      check("irq_clear", {31'b0, irq}, 32'h0);
      btn_raw[2] = 1'b0;
      tick(10);
      btn_raw[0] = 1'b1;
      tick(10);
      rd(32'h104, 32'h1, "edge_bit0_masked");
      check("irq_masked", {31'b0, irq}, 32'h0);
      btn_raw[0] = 1'b0;
      tick(2);
`else
      rd(32'h10C, 32'h0, "no_mask_rd");
      wr(32'h10C, 32'hF);
      rd(32'h10C, 32'h0, "no_mask_write");
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
